// File: rtl/eq_serial_ctrl_amisha.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : eq_serial_ctrl_amisha
// Description : Sequential word-equality controller. Compares two WIDTH-bit
//               operands two bits per cycle through a single shared 2-bit
//               equality slice, LSB pair first, stopping at the first
//               mismatching pair. The result is flagged with a one-cycle
//               done pulse.
// Ports       : clk_amisha     - clock, rising edge
//               rst_n_amisha   - synchronous active-low reset
//               start_amisha   - request, sampled only while idle
//               a_amisha       - operand A, captured on accepted start
//               b_amisha       - operand B, captured on accepted start
//               busy_amisha    - high while comparing and in the done cycle
//               done_amisha    - one-cycle result-valid pulse
//               aeqb_amisha    - 1 = operands equal, held until next start
//               mm_idx_amisha  - first mismatching pair index
//                                (only when EQ_MISMATCH_IDX_EN is defined)
// Options     : EQ_MISMATCH_IDX_EN - adds the mismatch index output
// Revision    : 1.0 - initial release
// ============================================================================
module eq_serial_ctrl_amisha #(
    parameter int WIDTH = 16,                                      // even, >= 2
    parameter int IDXW  = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic             start_amisha,
    input  logic [WIDTH-1:0] a_amisha,
    input  logic [WIDTH-1:0] b_amisha,
    output logic             busy_amisha,
    output logic             done_amisha,
    output logic             aeqb_amisha
`ifdef EQ_MISMATCH_IDX_EN
    ,
    output logic [IDXW-1:0]  mm_idx_amisha
`endif
);

    localparam int NP = WIDTH / 2;

    // Index of the last pair; the compare always leaves CMP here at the latest,
    // so the pair counter never wraps.
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NP - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_aeqb;
`ifdef EQ_MISMATCH_IDX_EN
    logic [IDXW-1:0]  r_mm_idx;
`endif

    logic [1:0]       w_a_pair;
    logic [1:0]       w_b_pair;
    logic             w_eq_pair;

    // Select the current pair from the captured operands.
    always_comb begin
        w_a_pair = 2'b00;
        w_b_pair = 2'b00;
        for (int p = 0; p < NP; p++) begin
            if (r_idx == IDXW'(p)) begin
                w_a_pair = r_a[2*p +: 2];
                w_b_pair = r_b[2*p +: 2];
            end
        end
    end

    // Shared 2-bit equality slice.
    assign w_eq_pair = (w_a_pair[0] ~^ w_b_pair[0]) & (w_a_pair[1] ~^ w_b_pair[1]);

    always_ff @(posedge clk_amisha) begin
        if (!rst_n_amisha) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_aeqb   <= 1'b0;
`ifdef EQ_MISMATCH_IDX_EN
            r_mm_idx <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_amisha) begin
                        r_a      <= a_amisha;
                        r_b      <= b_amisha;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_aeqb   <= 1'b0;   // stale result cleared until the new one lands
`ifdef EQ_MISMATCH_IDX_EN
                        r_mm_idx <= '0;
`endif
                        r_state  <= S_CMP;
                    end
                end

                S_CMP: begin
                    if (!w_eq_pair) begin
                        r_aeqb   <= 1'b0;
`ifdef EQ_MISMATCH_IDX_EN
                        r_mm_idx <= r_idx;
`endif
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_idx == c_LAST_IDX) begin
                        r_aeqb   <= 1'b1;
`ifdef EQ_MISMATCH_IDX_EN
                        r_mm_idx <= '0;
`endif
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx    <= r_idx + IDXW'(1);
                    end
                end

                S_DONE: begin
                    // Start is ignored here because the requester still sees busy.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_amisha   = r_busy;
    assign done_amisha   = r_done;
    assign aeqb_amisha   = r_aeqb;
`ifdef EQ_MISMATCH_IDX_EN
    assign mm_idx_amisha = r_mm_idx;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eq_serial_ctrl_amisha.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_eq_serial_ctrl_amisha
// Description : Self-checking bench for eq_serial_ctrl_amisha (WIDTH=16).
//               Expected results come from a word-level model: equality of
//               the whole operands, the lowest differing 2-bit pair, and the
//               resulting done latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eq_serial_ctrl_amisha;

    localparam int WIDTH = 16;
    localparam int NP    = WIDTH / 2;
    localparam int IDXW  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             aeqb;
`ifdef EQ_MISMATCH_IDX_EN
    logic [IDXW-1:0]  mm_idx;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    eq_serial_ctrl_amisha #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk_amisha    (clk),
        .rst_n_amisha  (rst_n),
        .start_amisha  (start),
        .a_amisha      (a_in),
        .b_amisha      (b_in),
        .busy_amisha   (busy),
        .done_amisha   (done),
        .aeqb_amisha   (aeqb)
`ifdef EQ_MISMATCH_IDX_EN
        ,
        .mm_idx_amisha (mm_idx)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest 2-bit pair where the operands differ, or -1 when equal.
    function automatic int first_mm(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int p = 0; p < NP; p++) begin
            if (((a >> (2 * p)) & 16'd3) != ((b >> (2 * p)) & 16'd3))
                return p;
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " aeqb"}, 32'(aeqb), 32'd0);
`ifdef EQ_MISMATCH_IDX_EN
        chk({tag, " mm_idx"}, 32'(mm_idx), 32'd0);
`endif
    endtask

    // Entered at a negedge; leaves at the negedge of the first IDLE cycle
    // after done, so a following call starts back-to-back.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit perturb);
        int          p;
        int          lat;
        logic        exp_eq;
        logic [31:0] exp_mm;
        p      = first_mm(a, b);
        exp_eq = (p < 0);
        lat    = exp_eq ? NP + 1 : p + 2;
        exp_mm = exp_eq ? 32'd0 : 32'(p);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        @(posedge clk);                                  // edge k: accepted
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (perturb && c == 2) begin
                start = 1'b1;                            // must be ignored
                a_in  = ~a;
                b_in  = a;
            end else begin
                start = 1'b0;
            end
            chk($sformatf("busy %h/%h c%0d", a, b, c), 32'(busy), 32'(c <= lat));
            chk($sformatf("done %h/%h c%0d", a, b, c), 32'(done), 32'(c == lat));
            chk($sformatf("aeqb %h/%h c%0d", a, b, c), 32'(aeqb),
                32'((c >= lat) ? exp_eq : 1'b0));
`ifdef EQ_MISMATCH_IDX_EN
            chk($sformatf("mm_idx %h/%h c%0d", a, b, c), 32'(mm_idx),
                (c >= lat) ? exp_mm : 32'd0);
`else
            if (exp_mm > 32'd7) chk("mm range", exp_mm, 32'd0);
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               mode;

        // Reset held with start asserted: nothing may be captured.
        rst_n = 1'b0;
        start = 1'b1;
        a_in  = 16'hFFFF;
        b_in  = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            chk_idle("reset");
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk_idle("post-reset");

        // Directed compares, run back-to-back.
        do_op(16'hA5C3, 16'hA5C3, 1'b0);
        do_op(16'h1234, 16'h1234, 1'b0);   // aeqb must drop from 1 during CMP
        do_op(16'h0001, 16'h0000, 1'b0);
        do_op(16'h8000, 16'h0000, 1'b0);

        // Start pulse and operand change while busy.
        do_op(16'h3C3C, 16'h3C3C, 1'b1);
        do_op(16'h0040, 16'h0000, 1'b1);

        // Reset during cycle 4 of a compare.
        start = 1'b1;
        a_in  = 16'h5555;
        b_in  = 16'h5555;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("midrst busy c%0d", c), 32'(busy), 32'd1);
            chk($sformatf("midrst done c%0d", c), 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle("midrst after");
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("midrst no done %0d", c), 32'(done), 32'd0);
            chk($sformatf("midrst no busy %0d", c), 32'(busy), 32'd0);
        end
        do_op(16'h5555, 16'h5555, 1'b0);

        // Randomized compares.
        for (int i = 0; i < 24; i++) begin
            ra   = 16'($urandom);
            mode = $urandom_range(0, 2);
            case (mode)
                0:       rb = ra;
                1:       rb = 16'($urandom);
                default: rb = ra ^ (16'd1 << $urandom_range(0, 15));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eq_serial_ctrl_amisha.md
Name: eq_serial_ctrl_amisha

Overview:
- Sequential word-equality controller. It compares two WIDTH-bit operands two bits per cycle, using one shared 2-bit equality slice (eq2 datapath function), and sequences that slice across the operand pairs.
- Sits between a requester that issues a start pulse and the 2-bit comparator resource.
- Stops early on the first mismatching pair and reports the result with a one-cycle done pulse.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 2; number of pairs NP = WIDTH/2.
- IDXW, $clog2(WIDTH/2) (minimum 1), width of the internal pair index and of the optional mismatch index.

Ports:
- clk_amisha  input  1  single clock; all state updates on rising edge.
- rst_n_amisha  input  1  reset, synchronous, active-low.
- start_amisha  input  1  request; sampled only in IDLE.
- a_amisha  input  WIDTH  operand A; captured on an accepted start.
- b_amisha  input  WIDTH  operand B; captured on an accepted start.
- busy_amisha  output  1  high in CMP and DONE states.
- done_amisha  output  1  one-cycle pulse when the result is valid.
- aeqb_amisha  output  1  1 = operands equal; valid from the done cycle and held until the next accepted start.
- mm_idx_amisha  output  IDXW  pair index of the first mismatch (present only with EQ_MISMATCH_IDX_EN).

Behaviour:
- Reset: when rst_n_amisha=0 at an edge, state=IDLE, pair index=0, busy=0, done=0, aeqb=0, captured operands=0, mm_idx=0.
- Reset mid-operation aborts the compare. No done pulse is issued.
- States: IDLE, CMP, DONE. All outputs are registered.
- IDLE: if start=1 at edge k, capture a and b, set idx=0 and go to CMP; busy=1 from cycle k+1. If start=0, stay in IDLE.
- CMP: each cycle compares the captured pair at bits [2*idx+1 : 2*idx] (LSB pair first).
  - eq_pair = (a_pair[0]~^b_pair[0]) & (a_pair[1]~^b_pair[1]).
  - Mismatch: aeqb<=0 and go to DONE.
  - Match with idx==NP-1: aeqb<=1 and go to DONE.
  - Otherwise: idx<=idx+1 and stay in CMP.
- DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE. busy=0 the following cycle.
- Latency, with start accepted at edge k:
  - Mismatch in pair p: done high during cycle k+p+2.
  - Full match: done high during cycle k+NP+1 (cycle k+9 for WIDTH=16).
  - Back-to-back operation: a start in the first IDLE cycle after DONE is accepted.
- start while busy=1 is ignored and not queued.
- Operand input changes after capture have no effect on the compare in progress.
- aeqb holds its last result through IDLE. On an accepted start it is cleared to 0 until the new result is written.
- The idx counter never wraps: CMP always exits at idx==NP-1.
- WIDTH=2: one CMP cycle; done at k+2.

Optional Feature:
- Macro: EQ_MISMATCH_IDX_EN.
- Defined:
  - mm_idx_amisha port exists.
  - On a mismatch exit it is loaded with idx of the failing pair; on a full match it is loaded with 0.
  - It is valid with done and held until the next accepted start, which clears it to 0.
  - Reset value is 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n_amisha=0 for 2 cycles with start=1 -> busy=0, done=0, aeqb=0, and no capture occurs.
- Equal compare, WIDTH=16: a=b=16'hA5C3, start at edge 0 -> busy for cycles 1..9, done=1 only in cycle 9, aeqb=1 held afterwards; mm_idx=0 if enabled.
- Early mismatch: a=16'h0001, b=16'h0000 -> done in cycle 2, aeqb=0, mm_idx=0. Then a=16'h8000, b=16'h0000 -> done in cycle 9, aeqb=0, mm_idx=7.
- Busy and operand isolation: during CMP, pulse start and change a/b to differing values -> the original compare completes unchanged and exactly one done pulse is seen.
- Reset mid-operation: assert rst_n_amisha=0 at cycle 4 of a compare -> state=IDLE, no done pulse. A fresh start after release gives the correct result.
- Back-to-back: start in the first IDLE cycle after DONE with a=16'h1234, b=16'h1234 -> accepted, aeqb cleared to 0 during CMP, done 9 cycles later with aeqb=1.
